alu_result_buffer: RTL and testbench
====================================

# alu_result_buffer

Downstream stage of the HAVEN ALU DUT: captures each result the ALU emits on EX_ALU/EX_ALU_VLD into a small FIFO and re-presents it as a valid/ready stream to the result sink (scoreboard bridge or next pipeline stage). The ALU output has no backpressure, so the block tracks operations already issued to the ALU and drops ALU_RDY early enough that every in-flight result is guaranteed a FIFO slot. Errors (overflow, unexpected result) are flagged sticky for the GA coverage/scoreboard layer.

## Interface
- DATA_WIDTH, 8, width of ALU result EX_ALU and OUT_DATA
- DEPTH, 8, FIFO entries; power of two, >= 2
- MAX_INFLIGHT, 4, maximum ALU operations issued but not yet returned; >= 1, <= DEPTH
- CLK  in  1  clock; all logic on rising edge
- RST  in  1  reset, synchronous, active-high
- ACT  in  1  operation issued to ALU this cycle (counted only when ALU_RDY=1)
- EX_ALU  in  DATA_WIDTH  ALU result
- EX_ALU_VLD  in  1  EX_ALU valid this cycle
- ALU_RDY  out  1  ALU may accept a new operation
- OUT_DATA  out  DATA_WIDTH  head-of-FIFO result
- OUT_VLD  out  1  OUT_DATA valid
- OUT_RDY  in  1  sink accepts OUT_DATA
- FILL_LEVEL  out  $clog2(DEPTH)+1  entries currently stored
- ERR_OVF  out  1  sticky: result arrived with FIFO full and no pop
- ERR_UNEXP  out  1  sticky: result arrived with zero ops in flight

## Operation
- Issue: issue = ACT & ALU_RDY. Return: ret = EX_ALU_VLD.
- In-flight counter INF (0..MAX_INFLIGHT): INF += issue, -= ret (ret only when INF>0); simultaneous issue+ret leaves INF unchanged.
- Push = EX_ALU_VLD & (not full or pop). Pop = OUT_VLD & OUT_RDY.
- ALU_RDY = (FILL_LEVEL + INF < DEPTH) & (INF < MAX_INFLIGHT); computed from registered state only, no combinational path from ACT/EX_ALU_VLD/OUT_RDY.
- FIFO: circular buffer, read/write pointers wrap modulo DEPTH; FILL_LEVEL +1 on push only, -1 on pop only, unchanged on both.
- Full (FILL_LEVEL=DEPTH) with push and pop same cycle: both succeed, no error.
- Empty with EX_ALU_VLD: value written, visible next cycle (no bypass).
- ERR_OVF set when EX_ALU_VLD & full & ~pop; result discarded, INF still decremented.
- ERR_UNEXP set when EX_ALU_VLD & INF=0; result still pushed if space.
- Error flags clear only on RST.

## Timing
- Reset values: ALU_RDY=0 during RST, 1 in first cycle after RST released; OUT_VLD=0, OUT_DATA=0, FILL_LEVEL=0, ERR_OVF=0, ERR_UNEXP=0; INF=0, pointers=0.
- Latency EX_ALU_VLD -> OUT_VLD: 1 cycle into empty FIFO.
- OUT_VLD/OUT_DATA stable while OUT_VLD & ~OUT_RDY; next entry appears the cycle after pop.
- Throughput: one push and one pop per cycle sustained.
- ALU_RDY reflects issue/return/pop of the previous cycle (1-cycle registered view).
- RST mid-operation: FIFO contents and INF discarded at the reset edge; results returning after reset count as unexpected.

## Test plan
- Single op: DEPTH=8, ACT 1 cycle, EX_ALU=0x5A 2 cycles later, OUT_RDY=1 -> OUT_VLD=1 with 0x5A the next cycle, FILL_LEVEL 1 then 0, no errors.
- Backpressure fill: OUT_RDY=0, ACT held high, ALU returns each op -> ALU_RDY drops once FILL_LEVEL+INF=8; exactly 8 results stored in order; ERR_OVF=0.
- Full with simultaneous push/pop: FIFO at 8, OUT_RDY=1 and EX_ALU_VLD same cycle -> FILL_LEVEL stays 8, order preserved across pointer wrap.
- Forced overflow: FIFO full, OUT_RDY=0, inject EX_ALU_VLD=1 (0xFF) -> ERR_OVF=1 next cycle and stays, 0xFF never appears on OUT_DATA.
- Unexpected result: after reset, EX_ALU_VLD=1 with no ACT -> ERR_UNEXP=1, value 0x11 output; INF stays 0.
- Reset mid-stream: 3 entries stored, 2 in flight, assert RST one cycle -> all outputs at reset values; late returns set ERR_UNEXP.

Source files
------------

// File: rtl/alu_result_buffer.sv
// Result FIFO behind the HAVEN ALU. It counts operations in flight so that every
// result the ALU returns already has a reserved slot. Overflow and unexpected results raise sticky flags.
module alu_result_buffer #(
  parameter int DATA_WIDTH   = 8,
  parameter int DEPTH        = 8,
  parameter int MAX_INFLIGHT = 4
) (
  input  logic                    CLK,
  input  logic                    RST,
  input  logic                    ACT,
  input  logic [DATA_WIDTH-1:0]   EX_ALU,
  input  logic                    EX_ALU_VLD,
  output logic                    ALU_RDY,
  output logic [DATA_WIDTH-1:0]   OUT_DATA,
  output logic                    OUT_VLD,
  input  logic                    OUT_RDY,
  output logic [$clog2(DEPTH):0]  FILL_LEVEL,
  output logic                    ERR_OVF,
  output logic                    ERR_UNEXP
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam int OCC_W = CNT_W + 1;
  localparam int INF_W = $clog2(MAX_INFLIGHT + 1);

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0]      wr_ptr;
  logic [PTR_W-1:0]      rd_ptr;
  logic [INF_W-1:0]      inf;
  logic [OCC_W-1:0]      occupancy;
  logic                  full;
  logic                  issue;
  logic                  ret_dec;
  logic                  push;
  logic                  pop;

  assign full     = (FILL_LEVEL == CNT_W'(DEPTH));
  assign OUT_VLD  = (FILL_LEVEL != '0);
  assign OUT_DATA = OUT_VLD ? mem[rd_ptr] : '0;
  assign pop      = OUT_VLD & OUT_RDY;
  assign push     = EX_ALU_VLD & (~full | pop);

  // Stored entries plus results still owed by the ALU must never exceed the FIFO size
  assign occupancy = OCC_W'(FILL_LEVEL) + OCC_W'(inf);
  assign ALU_RDY   = ~RST & (occupancy < OCC_W'(DEPTH)) & (inf < INF_W'(MAX_INFLIGHT));
  assign issue     = ACT & ALU_RDY;
  assign ret_dec   = EX_ALU_VLD & (inf != '0);

  always_ff @(posedge CLK) begin
    if (push && !RST) begin
      mem[wr_ptr] <= EX_ALU;
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      FILL_LEVEL <= '0;
      inf        <= '0;
      ERR_OVF    <= 1'b0;
      ERR_UNEXP  <= 1'b0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      if (push && !pop) begin
        FILL_LEVEL <= FILL_LEVEL + 1'b1;
      end else if (pop && !push) begin
        FILL_LEVEL <= FILL_LEVEL - 1'b1;
      end
      if (issue && !ret_dec) begin
        inf <= inf + 1'b1;
      end else if (ret_dec && !issue) begin
        inf <= inf - 1'b1;
      end
      // A dropped result still retires its in-flight slot through ret_dec above
      if (EX_ALU_VLD && full && !pop) begin
        ERR_OVF <= 1'b1;
      end
      if (EX_ALU_VLD && (inf == '0)) begin
        ERR_UNEXP <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_alu_result_buffer.sv
// Directed bench for alu_result_buffer: a vector table covers the main stream,
// and hand-written sequences cover unexpected results and a reset issued mid-stream.
module tb_alu_result_buffer;

  logic       CLK = 1'b0;
  logic       RST = 1'b1;
  logic       ACT = 1'b0;
  logic [7:0] EX_ALU = 8'h00;
  logic       EX_ALU_VLD = 1'b0;
  logic       OUT_RDY = 1'b0;
  logic       ALU_RDY;
  logic [7:0] OUT_DATA;
  logic       OUT_VLD;
  logic [3:0] FILL_LEVEL;
  logic       ERR_OVF;
  logic       ERR_UNEXP;

  int errors = 0;
  int checks = 0;

  typedef struct {
    logic       act;
    logic       vld;
    logic [7:0] data;
    logic       ordy;
    logic       e_rdy;
    logic       e_vld;
    logic [7:0] e_data;
    logic [3:0] e_fill;
    logic       e_ovf;
    logic       e_unexp;
  } vec_t;

  vec_t vecs[$];

  alu_result_buffer #(.DATA_WIDTH(8), .DEPTH(8), .MAX_INFLIGHT(4)) dut (
    .CLK        (CLK),
    .RST        (RST),
    .ACT        (ACT),
    .EX_ALU     (EX_ALU),
    .EX_ALU_VLD (EX_ALU_VLD),
    .ALU_RDY    (ALU_RDY),
    .OUT_DATA   (OUT_DATA),
    .OUT_VLD    (OUT_VLD),
    .OUT_RDY    (OUT_RDY),
    .FILL_LEVEL (FILL_LEVEL),
    .ERR_OVF    (ERR_OVF),
    .ERR_UNEXP  (ERR_UNEXP)
  );

  always #5 CLK = ~CLK;

  task automatic checkField(input string name, input logic [7:0] got, input logic [7:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  task automatic checkOutput(input string name, input logic e_rdy, input logic e_vld,
                             input logic [7:0] e_data, input logic [3:0] e_fill,
                             input logic e_ovf, input logic e_unexp);
    checkField({name, ".ALU_RDY"},    8'(ALU_RDY),    8'(e_rdy));
    checkField({name, ".OUT_VLD"},    8'(OUT_VLD),    8'(e_vld));
    checkField({name, ".OUT_DATA"},   OUT_DATA,       e_data);
    checkField({name, ".FILL_LEVEL"}, 8'(FILL_LEVEL), 8'(e_fill));
    checkField({name, ".ERR_OVF"},    8'(ERR_OVF),    8'(e_ovf));
    checkField({name, ".ERR_UNEXP"},  8'(ERR_UNEXP),  8'(e_unexp));
  endtask

  // Drive one cycle of inputs, then let the edge happen and settle just after it
  task automatic applyStimulus(input logic act, input logic vld, input logic [7:0] data,
                               input logic ordy);
    ACT        = act;
    EX_ALU_VLD = vld;
    EX_ALU     = data;
    OUT_RDY    = ordy;
    @(posedge CLK);
    #1;
  endtask

  task automatic addVec(input logic act, input logic vld, input logic [7:0] data,
                        input logic ordy, input logic e_rdy, input logic e_vld,
                        input logic [7:0] e_data, input logic [3:0] e_fill,
                        input logic e_ovf, input logic e_unexp);
    vec_t v;
    v.act = act; v.vld = vld; v.data = data; v.ordy = ordy;
    v.e_rdy = e_rdy; v.e_vld = e_vld; v.e_data = e_data; v.e_fill = e_fill;
    v.e_ovf = e_ovf; v.e_unexp = e_unexp;
    vecs.push_back(v);
  endtask

  task automatic resetDut();
    RST = 1'b1;
    ACT = 1'b0; EX_ALU_VLD = 1'b0; EX_ALU = 8'h00; OUT_RDY = 1'b0;
    repeat (2) @(posedge CLK);
    #1;
    RST = 1'b0;
    #1;
  endtask

  initial begin
    // single op: issue, result two cycles later, popped immediately
    addVec(1, 0, 8'h00, 1,  1, 0, 8'h00, 4'd0, 0, 0);
    addVec(0, 0, 8'h00, 1,  1, 0, 8'h00, 4'd0, 0, 0);
    addVec(0, 1, 8'h5A, 1,  1, 1, 8'h5A, 4'd1, 0, 0);
    addVec(0, 0, 8'h00, 1,  1, 0, 8'h00, 4'd0, 0, 0);
    // backpressure fill: ACT held, each op returns one cycle later
    addVec(1, 0, 8'h00, 0,  1, 0, 8'h00, 4'd0, 0, 0);
    addVec(1, 1, 8'hA0, 0,  1, 1, 8'hA0, 4'd1, 0, 0);
    addVec(1, 1, 8'hA1, 0,  1, 1, 8'hA0, 4'd2, 0, 0);
    addVec(1, 1, 8'hA2, 0,  1, 1, 8'hA0, 4'd3, 0, 0);
    addVec(1, 1, 8'hA3, 0,  1, 1, 8'hA0, 4'd4, 0, 0);
    addVec(1, 1, 8'hA4, 0,  1, 1, 8'hA0, 4'd5, 0, 0);
    addVec(1, 1, 8'hA5, 0,  1, 1, 8'hA0, 4'd6, 0, 0);
    addVec(1, 1, 8'hA6, 0,  0, 1, 8'hA0, 4'd7, 0, 0);
    addVec(1, 1, 8'hA7, 0,  0, 1, 8'hA0, 4'd8, 0, 0);
    addVec(1, 0, 8'h00, 0,  0, 1, 8'hA0, 4'd8, 0, 0);
    // full with push and pop in the same cycle, across the pointer wrap
    addVec(0, 1, 8'hC0, 1,  0, 1, 8'hA1, 4'd8, 0, 1);
    addVec(0, 1, 8'hC1, 1,  0, 1, 8'hA2, 4'd8, 0, 1);
    // forced overflow: 0xFF must be discarded
    addVec(0, 1, 8'hFF, 0,  0, 1, 8'hA2, 4'd8, 1, 1);
    addVec(0, 0, 8'h00, 0,  0, 1, 8'hA2, 4'd8, 1, 1);
    // drain: order preserved, 0xFF never shows up
    addVec(0, 0, 8'h00, 1,  1, 1, 8'hA3, 4'd7, 1, 1);
    addVec(0, 0, 8'h00, 1,  1, 1, 8'hA4, 4'd6, 1, 1);
    addVec(0, 0, 8'h00, 1,  1, 1, 8'hA5, 4'd5, 1, 1);
    addVec(0, 0, 8'h00, 1,  1, 1, 8'hA6, 4'd4, 1, 1);
    addVec(0, 0, 8'h00, 1,  1, 1, 8'hA7, 4'd3, 1, 1);
    addVec(0, 0, 8'h00, 1,  1, 1, 8'hC0, 4'd2, 1, 1);
    addVec(0, 0, 8'h00, 1,  1, 1, 8'hC1, 4'd1, 1, 1);
    addVec(0, 0, 8'h00, 1,  1, 0, 8'h00, 4'd0, 1, 1);

    RST = 1'b1;
    repeat (2) @(posedge CLK);
    #1;
    checkOutput("reset_hold", 0, 0, 8'h00, 4'd0, 0, 0);
    RST = 1'b0;
    #1;
    checkOutput("reset_release", 1, 0, 8'h00, 4'd0, 0, 0);

    for (int i = 0; i < vecs.size(); i++) begin
      applyStimulus(vecs[i].act, vecs[i].vld, vecs[i].data, vecs[i].ordy);
      checkOutput($sformatf("vec%0d", i), vecs[i].e_rdy, vecs[i].e_vld, vecs[i].e_data,
                  vecs[i].e_fill, vecs[i].e_ovf, vecs[i].e_unexp);
    end

    // unexpected result: still stored, in-flight count must stay at zero
    resetDut();
    applyStimulus(0, 1, 8'h11, 0);
    checkOutput("unexp_push", 1, 1, 8'h11, 4'd1, 0, 1);
    applyStimulus(1, 0, 8'h00, 1);
    checkOutput("unexp_pop_issue1", 1, 0, 8'h00, 4'd0, 0, 1);
    applyStimulus(1, 0, 8'h00, 0);
    checkOutput("inflight2", 1, 0, 8'h00, 4'd0, 0, 1);
    applyStimulus(1, 0, 8'h00, 0);
    checkOutput("inflight3", 1, 0, 8'h00, 4'd0, 0, 1);
    applyStimulus(1, 0, 8'h00, 0);
    checkOutput("inflight_cap", 0, 0, 8'h00, 4'd0, 0, 1);
    applyStimulus(1, 1, 8'h12, 0);
    checkOutput("inflight_return", 1, 1, 8'h12, 4'd1, 0, 1);

    // reset mid-stream: three stored, two in flight
    resetDut();
    applyStimulus(1, 0, 8'h00, 0);
    applyStimulus(1, 1, 8'h21, 0);
    applyStimulus(1, 1, 8'h22, 0);
    applyStimulus(1, 1, 8'h23, 0);
    applyStimulus(1, 0, 8'h00, 0);
    checkOutput("midstream_state", 1, 1, 8'h21, 4'd3, 0, 0);
    RST = 1'b1;
    ACT = 1'b0;
    #1;
    checkField("midstream_rst_rdy", 8'(ALU_RDY), 8'h00);
    @(posedge CLK);
    #1;
    checkOutput("midstream_reset", 0, 0, 8'h00, 4'd0, 0, 0);
    RST = 1'b0;
    applyStimulus(0, 1, 8'h24, 0);
    checkOutput("late_return", 1, 1, 8'h24, 4'd1, 0, 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
